// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR comparator emulator: FSM encoding,
// LFSR seed/taps and the LFSR step function used by both the LFSR and the top.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 10;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Taps 16,14,13,11 expressed as a mask over a right-shifting register (tap k -> bit 16-k)
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_step(input logic [15:0] q);
      return {^(q & LFSR_TAPS), q[15:1]};
   endfunction

endpackage

// File: rtl/sar_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock, reseeds on reset.
module sar_lfsr16
   import sar_pkg::*;
(
   input  logic        clock,
   input  logic        resetb,
   output logic [15:0] q
);

   logic [15:0] r_lfsr;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= lfsr_step(r_lfsr);
      end
   end

   assign q = r_lfsr;

endmodule

// File: rtl/sar_comparator_emulator.sv
// Digital stand-in for the SAR analog front end: holds a sampled input code and
// answers each DAC trial with a registered comparator decision after a settle delay.
module sar_comparator_emulator
   import sar_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int SETTLE_CYCLES = 4,
   parameter int DITHER_LSB    = 0,
   parameter int CNT_W         = 5
)(
   input  logic             clock,
   input  logic             resetb,
   input  logic [WIDTH-1:0] vin_code,
   input  logic             sample,
   input  logic [WIDTH-1:0] dac_code,
   input  logic             dac_strobe,
   input  logic             dither_en,
   input  logic             err_clr,
   output logic             comp_out,
   output logic             comp_valid,
   output logic             busy,
   output logic [CNT_W-1:0] trial_cnt,
   output logic             proto_err
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [WIDTH:0] DITHER_WIN = (WIDTH+1)'(DITHER_LSB);

   state_t           r_state;
   logic [SW-1:0]    r_settle_cnt;
   logic [WIDTH-1:0] r_vin_held;
   logic [WIDTH-1:0] r_dac_held;
   logic             r_comp_out;
   logic             r_comp_valid;
   logic             r_busy;
   logic             r_proto_err;
   logic [CNT_W-1:0] r_trial_cnt;

   logic [15:0]      w_lfsr;
   logic [15:0]      w_lfsr_next;
   logic             w_dither_bit;
   logic [WIDTH-1:0] w_dac_cmp;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_abs_diff;
   logic             w_in_window;
   logic             w_decision;
   logic             w_busy_state;
   logic             w_violation;
   logic             w_fire;

   sar_lfsr16 u_lfsr (
      .clock  (clock),
      .resetb (resetb),
      .q      (w_lfsr)
   );

   // The decision is registered into the RESP cycle, so dither uses the LFSR value of that cycle
   assign w_lfsr_next  = lfsr_step(w_lfsr);
   assign w_dither_bit = |(w_lfsr_next & 16'h0001);

   assign w_dac_cmp   = (r_state == IDLE) ? dac_code : r_dac_held;
   assign w_diff      = {1'b0, r_vin_held} - {1'b0, w_dac_cmp};
   assign w_abs_diff  = w_diff[WIDTH] ? (~w_diff + 1'b1) : w_diff;
   assign w_in_window = dither_en && (DITHER_LSB > 0) && (w_abs_diff <= DITHER_WIN);
   assign w_decision  = w_in_window ? w_dither_bit : ~w_diff[WIDTH];

   assign w_busy_state = (r_state != IDLE);
   assign w_violation  = w_busy_state ? (sample | dac_strobe) : (sample & dac_strobe);

   // A single-cycle settle answers straight from IDLE; otherwise the last SETTLE cycle fires
   assign w_fire = !sample &&
                   (((r_state == IDLE) && dac_strobe && (SETTLE_CYCLES == 1)) ||
                    ((r_state == SETTLE) && (r_settle_cnt == SW'(1))));

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state      <= IDLE;
         r_settle_cnt <= '0;
         r_vin_held   <= '0;
         r_dac_held   <= '0;
         r_comp_out   <= 1'b0;
         r_comp_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_proto_err  <= 1'b0;
         r_trial_cnt  <= '0;
      end else begin
         r_comp_valid <= 1'b0;
         r_proto_err  <= w_violation | (r_proto_err & ~err_clr);

         if (w_fire) begin
            r_comp_valid <= 1'b1;
            r_comp_out   <= w_decision;
            if (r_trial_cnt != '1) begin
               r_trial_cnt <= r_trial_cnt + 1'b1;
            end
         end

         case (r_state)
            IDLE: begin
               if (sample) begin
                  r_vin_held  <= vin_code;
                  r_trial_cnt <= '0;
               end else if (dac_strobe) begin
                  r_dac_held   <= dac_code;
                  r_settle_cnt <= SW'(SETTLE_CYCLES - 1);
                  r_busy       <= 1'b1;
                  r_state      <= (SETTLE_CYCLES == 1) ? RESP : SETTLE;
               end
            end
            SETTLE: begin
               if (sample) begin
                  r_vin_held  <= vin_code;
                  r_trial_cnt <= '0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_settle_cnt <= r_settle_cnt - 1'b1;
                  if (r_settle_cnt == SW'(1)) begin
                     r_state <= RESP;
                  end
               end
            end
            RESP: begin
               if (sample) begin
                  r_vin_held  <= vin_code;
                  r_trial_cnt <= '0;
               end
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign comp_out   = r_comp_out;
   assign comp_valid = r_comp_valid;
   assign busy       = r_busy;
   assign trial_cnt  = r_trial_cnt;
   assign proto_err  = r_proto_err;

endmodule
